// File: rtl/irrigation_sequencer.sv
// Irrigation sequencer: mode selection, valve control, tank refill and BCD run timer.
// Optional MANUAL_OVERRIDE_EN adds force_start, which starts a cycle regardless of soil moisture.
module irrigation_sequencer #(
  parameter logic [3:0] SPRINKLE_MIN     = 4'd3,
  parameter logic [3:0] DRIP_MIN         = 4'd5,
  parameter logic [3:0] FILL_TIMEOUT_MIN = 4'd4
) (
  input  logic       clk,
  input  logic       clear_n,
  input  logic       tick_1hz,
  input  logic       start,
  input  logic       abort,
  input  logic       soil_dry,
  input  logic       tank_low,
  input  logic       tank_full,
  input  logic       humid_high,
`ifdef MANUAL_OVERRIDE_EN
  input  logic       force_start,
`endif
  output logic       valve_in,
  output logic       sprinkler_en,
  output logic       drip_en,
  output logic       busy,
  output logic       fault,
  output logic       done,
  output logic [3:0] sec_units,
  output logic [2:0] sec_tens,
  output logic [3:0] min_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILL     = 3'd1,
    S_SPRINKLE = 3'd2,
    S_DRIP     = 3'd3,
    S_PAUSE    = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t     r_state;
  state_t     r_mode;
  logic       r_forced;
  logic       r_valve_in;
  logic       r_sprinkler_en;
  logic       r_drip_en;
  logic       r_busy;
  logic       r_fault;
  logic       r_done;
  logic [3:0] r_units;
  logic [2:0] r_tens;
  logic [3:0] r_min;

  state_t     w_nxt;
  logic       w_done;
  logic       w_force;
  logic       w_go;
  logic       w_sens_bad;
  logic       w_tick;
  logic       w_min_inc;
  logic [3:0] w_min_plus;
  logic [3:0] w_dur;
  logic       w_early;

`ifdef MANUAL_OVERRIDE_EN
  assign w_force = force_start;
`else
  assign w_force = 1'b0;
`endif

  assign w_sens_bad = tank_low & tank_full;
  assign w_go       = (start & soil_dry) | w_force;
  assign w_tick     = tick_1hz & (r_state inside {S_FILL, S_SPRINKLE, S_DRIP});
  assign w_min_inc  = w_tick & (r_units == 4'd9) & (r_tens == 3'd5);
  assign w_min_plus = (r_min == 4'd15) ? 4'd15 : r_min + 4'd1;
  assign w_dur      = (r_state == S_DRIP) ? DRIP_MIN : SPRINKLE_MIN;
  // A forced cycle keeps running even when the soil reports wet.
  assign w_early    = ~soil_dry & ~r_forced;

  always_comb begin
    w_nxt  = r_state;
    w_done = 1'b0;
    if (w_sens_bad) begin
      w_nxt = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (tank_low)  w_nxt = S_FILL;
          else if (w_go) w_nxt = humid_high ? S_DRIP : S_SPRINKLE;
        end
        S_FILL: begin
          if (abort)          w_nxt = S_IDLE;
          else if (tank_full) w_nxt = S_IDLE;
          else if (w_min_inc && (w_min_plus == FILL_TIMEOUT_MIN)) w_nxt = S_FAULT;
        end
        S_SPRINKLE, S_DRIP: begin
          if (abort) begin
            w_nxt = S_IDLE;
          end else if ((w_min_inc && (w_min_plus == w_dur)) || w_early) begin
            w_nxt  = S_IDLE;
            w_done = 1'b1;
          end else if (tank_low) begin
            w_nxt = S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (abort)          w_nxt = S_IDLE;
          else if (tank_full) w_nxt = r_mode;
        end
        S_FAULT: begin
          if (abort) w_nxt = S_IDLE;
        end
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so valves follow the state edge directly.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      r_state        <= S_IDLE;
      r_mode         <= S_SPRINKLE;
      r_forced       <= 1'b0;
      r_valve_in     <= 1'b0;
      r_sprinkler_en <= 1'b0;
      r_drip_en      <= 1'b0;
      r_busy         <= 1'b0;
      r_fault        <= 1'b0;
      r_done         <= 1'b0;
      r_units        <= 4'd0;
      r_tens         <= 3'd0;
      r_min          <= 4'd0;
    end else begin
      r_state        <= w_nxt;
      r_done         <= w_done;
      r_valve_in     <= (w_nxt == S_FILL) || (w_nxt == S_PAUSE);
      r_sprinkler_en <= (w_nxt == S_SPRINKLE);
      r_drip_en      <= (w_nxt == S_DRIP);
      r_busy         <= (w_nxt != S_IDLE);
      r_fault        <= (w_nxt == S_FAULT);
      if ((r_state == S_IDLE) && (w_nxt inside {S_SPRINKLE, S_DRIP})) begin
        r_mode   <= w_nxt;
        r_forced <= ~(start & soil_dry);
      end
      // Fresh run from IDLE restarts the timer; ticks coinciding with a transition are dropped.
      if ((r_state == S_IDLE) && (w_nxt inside {S_FILL, S_SPRINKLE, S_DRIP})) begin
        r_units <= 4'd0;
        r_tens  <= 3'd0;
        r_min   <= 4'd0;
      end else if (w_tick && (w_nxt == r_state)) begin
        if (r_units == 4'd9) begin
          r_units <= 4'd0;
          if (r_tens == 3'd5) begin
            r_tens <= 3'd0;
            r_min  <= w_min_plus;
          end else begin
            r_tens <= r_tens + 3'd1;
          end
        end else begin
          r_units <= r_units + 4'd1;
        end
      end
    end
  end

  assign valve_in     = r_valve_in;
  assign sprinkler_en = r_sprinkler_en;
  assign drip_en      = r_drip_en;
  assign busy         = r_busy;
  assign fault        = r_fault;
  assign done         = r_done;
  assign sec_units    = r_units;
  assign sec_tens     = r_tens;
  assign min_count    = r_min;
  assign state        = r_state;

endmodule

// File: tb/tb_irrigation_sequencer.sv
// Scoreboard bench for irrigation_sequencer: expected snapshots are queued as stimulus is driven
// and compared against the DUT outputs after the following clock edge.
module tb_irrigation_sequencer;

  logic       clk = 1'b0;
  logic       clear_n, tick_1hz, start, abort, soil_dry, tank_low, tank_full, humid_high;
  logic       valve_in, sprinkler_en, drip_en, busy, fault, done;
  logic [3:0] sec_units;
  logic [2:0] sec_tens;
  logic [3:0] min_count;
  logic [2:0] state;
`ifdef MANUAL_OVERRIDE_EN
  logic       force_start = 1'b0;
`endif

  irrigation_sequencer #(
    .SPRINKLE_MIN(4'd2), .DRIP_MIN(4'd3), .FILL_TIMEOUT_MIN(4'd4)
  ) dut (
    .clk(clk), .clear_n(clear_n), .tick_1hz(tick_1hz), .start(start), .abort(abort),
    .soil_dry(soil_dry), .tank_low(tank_low), .tank_full(tank_full), .humid_high(humid_high),
`ifdef MANUAL_OVERRIDE_EN
    .force_start(force_start),
`endif
    .valve_in(valve_in), .sprinkler_en(sprinkler_en), .drip_en(drip_en), .busy(busy),
    .fault(fault), .done(done), .sec_units(sec_units), .sec_tens(sec_tens),
    .min_count(min_count), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [19:0] FULL    = 20'hFFFFF;
  localparam logic [19:0] NOCHAIN = 20'hFF800;

  typedef struct {
    string       tag;
    logic [19:0] exp;
    logic [19:0] mask;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%05h expected=%05h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] snap();
    return {state, valve_in, sprinkler_en, drip_en, busy, fault, done,
            sec_units, sec_tens, min_count};
  endfunction

  // Expected snapshot built from the state code, elapsed seconds within the minute, minutes and done.
  function automatic logic [19:0] ex(input int st, input int secs, input int mn, input bit d);
    logic [2:0] s3;
    logic [3:0] su;
    logic [2:0] tn;
    logic [3:0] m4;
    int u, t;
    u  = secs % 10;
    t  = secs / 10;
    s3 = st[2:0];
    su = u[3:0];
    tn = t[2:0];
    m4 = mn[3:0];
    return {s3, (st == 1 || st == 4), (st == 2), (st == 3), (st != 0), (st == 5), d, su, tn, m4};
  endfunction

  task automatic push(input string tag, input logic [19:0] e, input logic [19:0] m);
    exp_t x;
    x.tag = tag; x.exp = e; x.mask = m;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      check(x.tag, snap() & x.mask, x.exp & x.mask);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One tick cycle with an expectation, then one quiet cycle.
  task automatic tick_chk(input string tag, input logic [19:0] e, input logic [19:0] m);
    tick_1hz = 1'b1;
    push(tag, e, m);
    cyc();
    tick_1hz = 1'b0;
    drain();
    cyc();
  endtask

  task automatic step_chk(input string tag, input logic [19:0] e, input logic [19:0] m);
    push(tag, e, m);
    cyc();
    drain();
  endtask

  initial begin
    clear_n = 1'b0; tick_1hz = 1'b0; start = 1'b0; abort = 1'b0; soil_dry = 1'b0;
    tank_low = 1'b0; tank_full = 1'b0; humid_high = 1'b0;
    #12;
    push("reset", ex(0, 0, 0, 0), FULL);
    drain();
    #10 clear_n = 1'b1;
    cyc();

    // Full sprinkler run of two minutes.
    soil_dry = 1'b1; start = 1'b1;
    step_chk("spr_enter", ex(2, 0, 0, 0), FULL);
    start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      if (k < 120) tick_chk($sformatf("spr_t%0d", k), ex(2, k % 60, k / 60, 0), FULL);
      else         tick_chk("spr_done", ex(0, 0, 0, 1), NOCHAIN);
    end
    step_chk("spr_done_clr", ex(0, 0, 0, 0), NOCHAIN);

    // Asynchronous reset in the middle of a run at 01:37.
    start = 1'b1;
    step_chk("rst_enter", ex(2, 0, 0, 0), FULL);
    start = 1'b0;
    for (int k = 1; k <= 97; k++) begin
      if (k == 97) tick_chk("rst_0137", ex(2, 37, 1, 0), FULL);
      else         tick_chk($sformatf("rst_t%0d", k), ex(2, k % 60, k / 60, 0), FULL);
    end
    #1 clear_n = 1'b0;
    #1 push("rst_async", ex(0, 0, 0, 0), FULL);
    drain();
    #1 clear_n = 1'b1;
    cyc();

    // Drip run paused by a low tank, then resumed, then ended early by wet soil.
    humid_high = 1'b1; start = 1'b1;
    step_chk("drip_enter", ex(3, 0, 0, 0), FULL);
    start = 1'b0;
    for (int k = 1; k <= 25; k++) tick_chk($sformatf("drip_t%0d", k), ex(3, k, 0, 0), FULL);
    tank_low = 1'b1;
    step_chk("pause_enter", ex(4, 25, 0, 0), FULL);
    for (int k = 1; k <= 10; k++) tick_chk($sformatf("pause_t%0d", k), ex(4, 25, 0, 0), FULL);
    tank_low = 1'b0; tank_full = 1'b1;
    step_chk("pause_resume", ex(3, 25, 0, 0), FULL);
    tank_full = 1'b0;
    tick_chk("resume_tick", ex(3, 26, 0, 0), FULL);
    soil_dry = 1'b0;
    step_chk("drip_early", ex(0, 0, 0, 1), NOCHAIN);
    step_chk("drip_early_clr", ex(0, 0, 0, 0), NOCHAIN);
    soil_dry = 1'b1; humid_high = 1'b0;

    // Refill that never reaches full times out after four minutes.
    tank_low = 1'b1;
    step_chk("fill_enter", ex(1, 0, 0, 0), FULL);
    for (int k = 1; k <= 240; k++) begin
      if (k < 240) tick_chk($sformatf("fill_t%0d", k), ex(1, k % 60, k / 60, 0), FULL);
      else         tick_chk("fill_timeout", ex(5, 0, 0, 0), NOCHAIN);
    end
    start = 1'b1;
    step_chk("fault_start", ex(5, 0, 0, 0), NOCHAIN);
    start = 1'b0; tank_low = 1'b0; abort = 1'b1;
    step_chk("fault_abort", ex(0, 0, 0, 0), NOCHAIN);
    abort = 1'b0;

    // Normal refill ending on tank_full.
    tank_low = 1'b1;
    step_chk("fill2_enter", ex(1, 0, 0, 0), FULL);
    tank_low = 1'b0; tank_full = 1'b1;
    step_chk("fill2_full", ex(0, 0, 0, 0), NOCHAIN);
    tank_full = 1'b0;

    // Inconsistent sensors during sprinkling.
    start = 1'b1;
    step_chk("sens_enter", ex(2, 0, 0, 0), FULL);
    start = 1'b0;
    for (int k = 1; k <= 5; k++) tick_chk($sformatf("sens_t%0d", k), ex(2, k, 0, 0), FULL);
    tank_low = 1'b1; tank_full = 1'b1;
    step_chk("sens_fault", ex(5, 0, 0, 0), NOCHAIN);
    start = 1'b1;
    step_chk("sens_start", ex(5, 0, 0, 0), NOCHAIN);
    abort = 1'b1;
    step_chk("sens_abort_bad", ex(5, 0, 0, 0), NOCHAIN);
    start = 1'b0; tank_low = 1'b0; tank_full = 1'b0;
    step_chk("sens_abort_ok", ex(0, 0, 0, 0), NOCHAIN);
    abort = 1'b0;

    // Start with wet soil is ignored; abort beats early finish and tick.
    soil_dry = 1'b0; start = 1'b1;
    step_chk("wet_start", ex(0, 0, 0, 0), NOCHAIN);
    soil_dry = 1'b1;
    step_chk("ab_enter", ex(2, 0, 0, 0), FULL);
    start = 1'b0;
    for (int k = 1; k <= 3; k++) tick_chk($sformatf("ab_t%0d", k), ex(2, k, 0, 0), FULL);
    tick_1hz = 1'b1; abort = 1'b1; soil_dry = 1'b0;
    step_chk("ab_combo", ex(0, 3, 0, 0), FULL);
    tick_1hz = 1'b0; abort = 1'b0; soil_dry = 1'b1;
    step_chk("ab_after", ex(0, 3, 0, 0), FULL);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
